// File: rtl/my_logic_unit_seq_pkg.sv
// Shared definitions for the sliced bitwise logic unit: function codes,
// FSM state encoding and the single-bit reference gate function.
package my_logic_unit_seq_pkg;

    typedef enum logic [2:0] {
        LOGIC_AND  = 3'b000,
        LOGIC_OR   = 3'b001,
        LOGIC_XOR  = 3'b010,
        LOGIC_NOR  = 3'b011,
        LOGIC_NAND = 3'b100,
        LOGIC_XNOR = 3'b101,
        LOGIC_PASS = 3'b110,
        LOGIC_NOT  = 3'b111
    } logic_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One bit of the selected logic function; PASS/NOT look at a only.
    function automatic logic logic_bit(input logic_op_t op, input logic a, input logic b);
        logic r;
        r = a & b;
        case (op)
            LOGIC_AND:  r = a & b;
            LOGIC_OR:   r = a | b;
            LOGIC_XOR:  r = a ^ b;
            LOGIC_NOR:  r = ~(a | b);
            LOGIC_NAND: r = ~(a & b);
            LOGIC_XNOR: r = ~(a ^ b);
            LOGIC_PASS: r = a;
            LOGIC_NOT:  r = ~a;
            default:    r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/my_logic_unit_seq_slice.sv
// Combinational W-bit logic slice: every bit applies the same function
// to the matching operand bits.
module my_logic_slice
    import my_logic_unit_seq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    output logic [W-1:0] out,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic_op_t    op
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign out[i] = logic_bit(op, in1[i], in2[i]);
    end

endmodule

// File: rtl/my_logic_unit_seq.sv
// Multi-cycle bitwise logic unit. Operands are captured on start and
// processed SLICE bits per cycle, LSB slice first; the full result is
// published on out/zero together with a one-cycle done pulse.
module my_logic_unit_seq
    import my_logic_unit_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if ((SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_width_check
        $error("my_logic_unit_seq: WIDTH must be a nonzero multiple of SLICE");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic_op_t        op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] res_sl;
    logic [WIDTH-1:0] acc_ins;

    my_logic_slice #(
        .W (SLICE)
    ) u_slice (
        .out (res_sl),
        .in1 (a_sl),
        .in2 (b_sl),
        .op  (op_q)
    );

    // Select operand slice k and merge the computed slice into the accumulator.
    always_comb begin
        a_sl    = '0;
        b_sl    = '0;
        acc_ins = acc_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (k_q == CW'(i)) begin
                a_sl = a_q[i*SLICE +: SLICE];
                b_sl = b_q[i*SLICE +: SLICE];
                acc_ins[i*SLICE +: SLICE] = res_sl;
            end
        end
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and datapath registers.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        out_d   = out_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    op_d    = logic_op_t'(op);
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = acc_ins;
                k_d   = k_q + CW'(1);
                // Publish straight from the merged value so the last slice
                // lands on out in the same edge that enters DONE.
                if (k_q == CW'(N - 1)) begin
                    k_d     = '0;
                    out_d   = acc_ins;
                    zero_d  = (acc_ins == '0);
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= LOGIC_AND;
            acc_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_my_logic_unit_seq.sv
// Directed bench for my_logic_unit_seq: default 32/8 instance plus a
// single-slice 32/32 instance sharing clock, reset and operands.
module tb_my_logic_unit_seq;

    logic        clk = 1'b0;
    logic        reset, start, start2;
    logic [2:0]  op;
    logic [31:0] in1, in2;
    logic        busy, done, zero;
    logic [31:0] out;
    logic        busy2, done2, zero2;
    logic [31:0] out2;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    my_logic_unit_seq #(
        .WIDTH (32),
        .SLICE (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .zero  (zero)
    );

    my_logic_unit_seq #(
        .WIDTH (32),
        .SLICE (32)
    ) dut32 (
        .clk   (clk),
        .reset (reset),
        .start (start2),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy2),
        .done  (done2),
        .out   (out2),
        .zero  (zero2)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on the 32/8 instance and check the full 5-cycle sequence.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out, input logic exp_zero);
        op = o; in1 = a; in2 = b; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            total_cnt++;
            if ({busy, done} !== 2'b10)
                $display("FAIL %s run cycle %0d: busy/done=%b expected 10", name, c, {busy, done});
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if ({busy, done, zero, out} !== {1'b0, 1'b1, exp_zero, exp_out})
            $display("FAIL %s done: busy/done/zero=%b out=%h expected %b out=%h",
                     name, {busy, done, zero}, out, {2'b01, exp_zero}, exp_out);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({busy, done, out} !== {2'b00, exp_out})
            $display("FAIL %s after: busy/done=%b out=%h expected 00 out=%h", name, {busy, done}, out, exp_out);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; start2 = 1'b1;
        op = 3'($urandom_range(0, 7)); in1 = $urandom; in2 = $urandom;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++;
            if ({busy, done, zero, out, busy2, done2, zero2, out2} !== 70'd0)
                $display("FAIL reset hold %0d: busy/done/zero=%b out=%h (x32 %b %h) expected all 0",
                         i, {busy, done, zero}, out, {busy2, done2, zero2}, out2);
            else pass_cnt++;
        end
        reset = 1'b0; start = 1'b0; start2 = 1'b0;
        step();
        total_cnt++;
        if ({busy, done, zero, out, busy2, done2, zero2, out2} !== 70'd0)
            $display("FAIL reset release: busy/done/zero=%b out=%h expected all 0", {busy, done, zero}, out);
        else pass_cnt++;
    endtask

    task automatic test_nor_timing();
        run_op("nor", 3'b011, 32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 1'b0);
    endtask

    task automatic test_xor_zero();
        run_op("xor_self", 3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1);
    endtask

    task automatic test_op_sweep();
        logic [31:0] exp_tbl [8];
        exp_tbl = '{32'hF000A500, 32'hFFF0FFA5, 32'h0FF05AA5, 32'h000F005A,
                    32'h0FFF5AFF, 32'hF00FA55A, 32'hF0F0A5A5, 32'h0F0F5A5A};
        for (int i = 0; i < 8; i++)
            run_op($sformatf("sweep_op%0d", i), 3'(i), 32'hF0F0A5A5, 32'hFF00FF00, exp_tbl[i], 1'b0);
    endtask

    task automatic test_ignored_start();
        int unsigned extra_done;
        op = 3'b000; in1 = 32'hFFFFFFFF; in2 = 32'h12345678; start = 1'b1;
        step();                       // cycle t+1
        start = 1'b0;
        step();                       // cycle t+2
        start = 1'b1; op = 3'b001; in1 = 32'h0F0F0F0F; in2 = 32'hA5A5A5A5;
        step();                       // cycle t+3
        start = 1'b0;
        total_cnt++;
        if ({busy, done} !== 2'b10)
            $display("FAIL ignored_start t+3: busy/done=%b expected 10", {busy, done});
        else pass_cnt++;
        step();                       // cycle t+4
        total_cnt++;
        if ({busy, done} !== 2'b10)
            $display("FAIL ignored_start t+4: busy/done=%b expected 10", {busy, done});
        else pass_cnt++;
        step();                       // cycle t+5
        total_cnt++;
        if ({done, out} !== {1'b1, 32'h12345678})
            $display("FAIL ignored_start done: done=%b out=%h expected 1 out=12345678", done, out);
        else pass_cnt++;
        extra_done = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (done || busy) extra_done++;
        end
        total_cnt++;
        if (extra_done !== 0)
            $display("FAIL ignored_start second: %0d busy/done cycles expected 0", extra_done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        op = 3'b010; in1 = 32'hAAAA5555; in2 = 32'h0000FFFF; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) step();
        total_cnt++;
        if ({done, out} !== {1'b1, 32'hAAAAAAAA})
            $display("FAIL b2b first done: done=%b out=%h expected 1 out=aaaaaaaa", done, out);
        else pass_cnt++;
        op = 3'b001; in1 = 32'h00000001; in2 = 32'h80000000; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            total_cnt++;
            if ({busy, done, out} !== {2'b10, 32'hAAAAAAAA})
                $display("FAIL b2b hold %0d: busy/done=%b out=%h expected 10 out=aaaaaaaa", c, {busy, done}, out);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if ({busy, done, zero, out} !== {3'b010, 32'h80000001})
            $display("FAIL b2b second done: busy/done/zero=%b out=%h expected 010 out=80000001",
                     {busy, done, zero}, out);
        else pass_cnt++;
        step();
    endtask

    task automatic test_abort();
        int unsigned seen_done;
        op = 3'b001; in1 = 32'h11111111; in2 = 32'h22222222; start = 1'b1;
        step();                       // cycle t+1, k=0
        start = 1'b0;
        step();                       // cycle t+2, k=1
        step();                       // cycle t+3, k=2
        reset = 1'b1;
        step();                       // cycle t+4
        reset = 1'b0;
        total_cnt++;
        if ({busy, done, zero, out} !== 35'd0)
            $display("FAIL abort: busy/done/zero=%b out=%h expected 000 out=00000000", {busy, done, zero}, out);
        else pass_cnt++;
        seen_done = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (done || busy || out != 32'd0) seen_done++;
        end
        total_cnt++;
        if (seen_done !== 0)
            $display("FAIL abort idle: %0d active cycles after abort expected 0", seen_done);
        else pass_cnt++;
    endtask

    task automatic test_single_slice();
        op = 3'b011; in1 = 32'h0000FFFF; in2 = 32'h00FF0000; start2 = 1'b1;
        step();                       // cycle t+1
        start2 = 1'b0;
        total_cnt++;
        if ({busy2, done2, out2} !== {2'b10, 32'h00000000})
            $display("FAIL slice32 run: busy/done=%b out=%h expected 10 out=00000000", {busy2, done2}, out2);
        else pass_cnt++;
        step();                       // cycle t+2
        total_cnt++;
        if ({busy2, done2, zero2, out2} !== {3'b010, 32'hFF000000})
            $display("FAIL slice32 done: busy/done/zero=%b out=%h expected 010 out=ff000000",
                     {busy2, done2, zero2}, out2);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({busy2, done2} !== 2'b00)
            $display("FAIL slice32 after: busy/done=%b expected 00", {busy2, done2});
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0; op = 3'b000; in1 = '0; in2 = '0;
        test_reset();
        test_nor_timing();
        test_xor_zero();
        test_op_sweep();
        test_ignored_start();
        test_back_to_back();
        test_abort();
        test_single_slice();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
